// File: rtl/trace_capture.sv
// Processor trace capture buffer: circular sample RAM with a trigger, a post-trigger
// window, and a pop-style readout of the frozen buffer oldest-first.
module trace_capture #(
    parameter int DEPTH  = 64,
    parameter int PC_W   = 12,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH),
    localparam int EW    = 7 + 2*PC_W + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rwe,
    input  logic              mwe,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] rData,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [31:0]       instAddr,
    input  logic [31:0]       memAddr,
    input  logic              arm,
    input  logic              clear,
    input  logic [1:0]        trig_mode,
    input  logic [31:0]       trig_addr,
    input  logic [CW:0]       post_count,
    input  logic              events_only,
    input  logic              rd_en,
    output logic [EW-1:0]     rd_data,
    output logic              rd_valid,
    output logic [1:0]        state,
    output logic [CW:0]       count,
    output logic              triggered
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW:0]   MAX_COUNT = (CW+1)'(DEPTH);
    localparam logic [CW:0]   MAX_POST  = (CW+1)'(DEPTH - 1);

    state_t          cur_state;
    state_t          next_state;
    logic [EW-1:0]   mem [DEPTH];
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [CW:0]     cnt;
    logic [CW-1:0]   post_left;
    logic [CW-1:0]   post_load;
    logic            trig_q;
    logic            qualified;
    logic            match;
    logic            capture;
    logic            fire;
    logic            read_accept;
    logic            restart;
    logic [EW-1:0]   entry;

    assign qualified = !events_only || rwe || mwe;
    assign post_load = (post_count > MAX_POST) ? MAX_POST[CW-1:0] : post_count[CW-1:0];
    assign entry     = {rwe, mwe, rd, instAddr[PC_W-1:0], memAddr[PC_W-1:0],
                        mwe ? memDataIn : rData};
    // Oldest entry sits count slots behind the write pointer; stays correct while popping.
    assign rd_ptr    = wr_ptr - cnt[CW-1:0];

    always_comb begin
        match = 1'b0;
        case (trig_mode)
            2'd0: match = 1'b1;
            2'd1: match = (instAddr == trig_addr);
            2'd2: match = mwe && (memAddr == trig_addr);
            2'd3: match = rwe && (rd == trig_addr[4:0]);
            default: match = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:  if (arm) next_state = ARMED;
                ARMED: if (qualified && match)
                           next_state = (post_load == '0) ? DONE : POST;
                POST:  if (qualified && post_left == CW'(1)) next_state = DONE;
                DONE:  if (arm) next_state = ARMED;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        capture     = !clear && qualified && (cur_state == ARMED || cur_state == POST);
        fire        = !clear && qualified && (cur_state == ARMED) && match;
        restart     = !clear && arm && (cur_state == IDLE || cur_state == DONE);
        read_accept = !clear && !arm && (cur_state == DONE) && (cnt != '0) && rd_en;
        state       = cur_state;
        count       = cnt;
        triggered   = trig_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            post_left <= '0;
            trig_q    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= read_accept;
            if (clear || restart) begin
                wr_ptr    <= '0;
                cnt       <= '0;
                post_left <= '0;
                trig_q    <= 1'b0;
            end else if (capture) begin
                wr_ptr <= wr_ptr + CW'(1);
                if (cnt != MAX_COUNT) cnt <= cnt + (CW+1)'(1);
                if (fire) begin
                    trig_q    <= 1'b1;
                    post_left <= post_load;
                end else if (cur_state == POST) begin
                    post_left <= post_left - CW'(1);
                end
            end else if (read_accept) begin
                rd_data <= mem[rd_ptr];
                cnt     <= cnt - (CW+1)'(1);
            end
        end
    end

    // Sample RAM has no reset; stale contents are never visible once the pointers reset.
    always_ff @(posedge clock) begin
        if (reset && capture) mem[wr_ptr] <= entry;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer entries (power of two, >=4).
REQ-002 SHALL have parameter PC_W, default 12, stored width of instAddr and memAddr.
REQ-003 SHALL have parameter DATA_W, default 32, stored data width.
REQ-004 SHALL define CW = log2(DEPTH) and entry width EW = 7 + 2*PC_W + DATA_W.
REQ-005 Ports (name  direction  width  meaning) SHALL be:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- rwe, mwe  in  1 each  processor regfile / data-memory write enables
- rd  in  5  regfile write register
- rData, memDataIn  in  DATA_W each  regfile write data / memory write data
- instAddr, memAddr  in  32 each  fetch address / data-memory address
- arm  in  1  start capture (single-cycle pulse)
- clear  in  1  abort and return to IDLE
- trig_mode  in  2  trigger select
- trig_addr  in  32  trigger compare value
- post_count  in  CW+1  samples kept after trigger
- events_only  in  1  1 = sample only when rwe|mwe
- rd_en  in  1  readout pop request
- rd_data  out  EW  entry {rwe, mwe, rd, instAddr[PC_W-1:0], memAddr[PC_W-1:0], data}
- rd_valid  out  1  rd_data valid this cycle
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  CW+1  valid entries held
- triggered  out  1  trigger has fired this capture

Function
REQ-006 Entry data field SHALL be memDataIn when mwe=1, else rData.
REQ-007 A cycle SHALL be qualified when events_only=0, or when events_only=1 and rwe|mwe=1.
REQ-008 IDLE: no writes; arm=1 -> ARMED next cycle; write pointer, count, triggered cleared.
REQ-009 ARMED: each qualified cycle writes at wr_ptr, wr_ptr increments modulo DEPTH (wrap), count saturates at DEPTH.
REQ-010 Trigger match: mode 0 immediate (first qualified ARMED cycle); mode 1 instAddr==trig_addr; mode 2 mwe=1 and memAddr==trig_addr; mode 3 rwe=1 and rd==trig_addr[4:0].
REQ-011 Trigger evaluated only on qualified ARMED cycles; matching sample SHALL be written, triggered set, post counter loaded with min(post_count, DEPTH-1), state -> POST (or DONE if loaded value is 0).
REQ-012 POST: each qualified cycle writes and decrements post counter; write leaving it at 0 SHALL move state to DONE next cycle.
REQ-013 DONE: no further writes; buffer frozen; read pointer = oldest entry = (wr_ptr - count) mod DEPTH.
REQ-014 Readout: rd_en=1 in DONE with count>0 -> rd_valid=1 with oldest entry exactly one cycle later; read pointer advances, count decrements.
REQ-015 rd_en with count=0 or outside DONE SHALL be ignored; rd_valid=0 next cycle.
REQ-016 rd_valid SHALL be a one-cycle pulse per accepted rd_en; back-to-back rd_en yields back-to-back entries in order.
REQ-017 clear=1 SHALL force IDLE next cycle from any state, priority over arm, rd_en and capture.
REQ-018 arm=1 in DONE SHALL restart (-> ARMED, count 0, triggered 0); arm in ARMED or POST ignored.
REQ-019 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-020 reset=0 at a clock edge SHALL set state IDLE, count 0, triggered 0, rd_valid 0, rd_data 0, pointers 0, in any state including mid-capture; buffer RAM contents need not be cleared.
REQ-021 reset SHALL take priority over clear, arm and rd_en.

Verification
REQ-022 DEPTH=8, mode 0, post_count=3, events_only=0, arm -> 4 entries captured, DONE, count=4, reads return trigger sample first.
REQ-023 Mode 1, trig_addr=0x20, 20 pre-trigger cycles, post_count=2 -> count=8, oldest 5 entries pre-trigger in wrap order, triggered=1.
REQ-024 events_only=1, rwe pulses every 3rd cycle, mode 3 rd=5 -> only rwe cycles stored; entry mwe bit 0, data=rData.
REQ-025 post_count=20 with DEPTH=8 -> clamped to 7, count=8, trigger sample is oldest read.
REQ-026 Reset low during POST -> state 0, count 0, rd_valid 0 next cycle; clear and arm same cycle in DONE -> IDLE.
REQ-027 9 rd_en pulses on count=8 -> 8 rd_valid pulses, ninth ignored, count=0.
